// File: rtl/five_stage_pkg.sv
// Shared constants for the five-stage hazard tracker: register index defaults and entry layout.
package five_stage_pkg;

  localparam int unsigned REG_INDEX_BITS_DEFAULT = 5;
  localparam logic [4:0]  REG_ZERO               = 5'd0;

  // Tracker entry is packed as {valid, rd, regwrite, mem_read}.
  localparam int unsigned TRK_FLAG_BITS    = 3;
  localparam logic        TRK_BUBBLE_VALID = 1'b0;

  localparam int unsigned STALL_COUNT_BITS = 32;
  localparam int unsigned CYCLE_COUNT_BITS = 32;

  function automatic int unsigned trk_entry_bits(input int unsigned rd_bits);
    return rd_bits + TRK_FLAG_BITS;
  endfunction

endpackage

// File: rtl/five_stage_hazard_detection_unit_if.sv
// Decode-side bus of the hazard detection unit: decode fields in, per-stage hazard flags out.
interface five_stage_hazard_detection_unit_if
  import five_stage_pkg::*;
#(
  parameter int unsigned REG_INDEX_BITS = REG_INDEX_BITS_DEFAULT
) ();

  logic                      decode_valid;
  logic [REG_INDEX_BITS-1:0] decode_rs1;
  logic [REG_INDEX_BITS-1:0] decode_rs2;
  logic                      decode_rs1_used;
  logic                      decode_rs2_used;
  logic [REG_INDEX_BITS-1:0] decode_rd;
  logic                      decode_regwrite;
  logic                      decode_mem_read;
  logic                      flush_execute;
  logic                      memory_stall;
  logic                      scan;

  logic                      rs1_hazard_execute;
  logic                      rs1_hazard_memory;
  logic                      rs1_hazard_writeback;
  logic                      rs2_hazard_execute;
  logic                      rs2_hazard_memory;
  logic                      rs2_hazard_writeback;
  logic                      true_data_hazard;
  logic [STALL_COUNT_BITS-1:0] stall_cycles;

  // Debug scan strobe; the consumer formats the printout.
  logic                        scan_active;
  logic [CYCLE_COUNT_BITS-1:0] scan_cycle;
  logic [31:0]                 scan_core;

  modport master (
    output decode_valid, decode_rs1, decode_rs2, decode_rs1_used, decode_rs2_used,
           decode_rd, decode_regwrite, decode_mem_read, flush_execute, memory_stall, scan,
    input  rs1_hazard_execute, rs1_hazard_memory, rs1_hazard_writeback,
           rs2_hazard_execute, rs2_hazard_memory, rs2_hazard_writeback,
           true_data_hazard, stall_cycles, scan_active, scan_cycle, scan_core
  );

  modport slave (
    input  decode_valid, decode_rs1, decode_rs2, decode_rs1_used, decode_rs2_used,
           decode_rd, decode_regwrite, decode_mem_read, flush_execute, memory_stall, scan,
    output rs1_hazard_execute, rs1_hazard_memory, rs1_hazard_writeback,
           rs2_hazard_execute, rs2_hazard_memory, rs2_hazard_writeback,
           true_data_hazard, stall_cycles, scan_active, scan_cycle, scan_core
  );

endinterface

// File: rtl/five_stage_writer_tracker_stage.sv
// One tracker stage register holding {valid, rd, regwrite, mem_read} with hold and bubble controls.
module five_stage_writer_tracker_stage
  import five_stage_pkg::*;
#(
  parameter int unsigned RdBits = REG_INDEX_BITS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic [RdBits-1:0] i_rd,
  input  logic              i_regwrite,
  input  logic              i_mem_read,
  output logic              o_valid,
  output logic [RdBits-1:0] o_rd,
  output logic              o_regwrite,
  output logic              o_mem_read
);

  localparam int unsigned EntryBits = trk_entry_bits(RdBits);

  logic [EntryBits-1:0] r_entry;
  logic [EntryBits-1:0] w_entry_d;
  logic [EntryBits-1:0] w_bubble;

  assign w_bubble = {TRK_BUBBLE_VALID, {(EntryBits - 1){1'b0}}};

  // Hold wins over bubble so a stalled load-use stays visible until the tracker advances.
  always_comb begin
    w_entry_d = r_entry;
    if (!i_hold) begin
      w_entry_d = i_bubble ? w_bubble : {i_valid, i_rd, i_regwrite, i_mem_read};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_entry <= w_bubble;
    end else begin
      r_entry <= w_entry_d;
    end
  end

  assign {o_valid, o_rd, o_regwrite, o_mem_read} = r_entry;

endmodule

// File: rtl/five_stage_hazard_detection_unit.sv
// Tracks in-flight destinations through EX/MEM/WB and flags decode source hazards and load-use stalls.
// Optional HAZARD_STALL_COUNTER_EN adds a saturating load-use stall counter on stall_cycles.
module five_stage_hazard_detection_unit
  import five_stage_pkg::*;
#(
  parameter int          CORE            = 0,
  parameter int unsigned REG_INDEX_BITS  = REG_INDEX_BITS_DEFAULT,
  parameter int          SCAN_CYCLES_MIN = 0,
  parameter int          SCAN_CYCLES_MAX = 1000
) (
  input logic                               clock,
  input logic                               reset,
  five_stage_hazard_detection_unit_if.slave bus
);

  logic                      w_ex_valid, w_ex_regwrite, w_ex_mem_read;
  logic [REG_INDEX_BITS-1:0] w_ex_rd;
  logic                      w_mem_valid, w_mem_regwrite, w_mem_mem_read;
  logic [REG_INDEX_BITS-1:0] w_mem_rd;
  logic                      w_wb_valid, w_wb_regwrite, w_wb_mem_read_unused;
  logic [REG_INDEX_BITS-1:0] w_wb_rd;

  logic w_true_data_hazard;
  logic w_ex_bubble;
  logic w_rs1_ex, w_rs1_mem, w_rs1_wb;
  logic w_rs2_ex, w_rs2_mem, w_rs2_wb;

  logic [CYCLE_COUNT_BITS-1:0] r_cycle;

  // A stalled or flushed decode slot enters EX as a single bubble.
  assign w_ex_bubble = w_true_data_hazard | bus.flush_execute | ~bus.decode_valid;

  five_stage_writer_tracker_stage #(.RdBits(REG_INDEX_BITS)) u_ex_stage (
    .clock      (clock),
    .reset      (reset),
    .i_hold     (bus.memory_stall),
    .i_bubble   (w_ex_bubble),
    .i_valid    (1'b1),
    .i_rd       (bus.decode_rd),
    .i_regwrite (bus.decode_regwrite),
    .i_mem_read (bus.decode_mem_read),
    .o_valid    (w_ex_valid),
    .o_rd       (w_ex_rd),
    .o_regwrite (w_ex_regwrite),
    .o_mem_read (w_ex_mem_read)
  );

  five_stage_writer_tracker_stage #(.RdBits(REG_INDEX_BITS)) u_mem_stage (
    .clock      (clock),
    .reset      (reset),
    .i_hold     (bus.memory_stall),
    .i_bubble   (1'b0),
    .i_valid    (w_ex_valid),
    .i_rd       (w_ex_rd),
    .i_regwrite (w_ex_regwrite),
    .i_mem_read (w_ex_mem_read),
    .o_valid    (w_mem_valid),
    .o_rd       (w_mem_rd),
    .o_regwrite (w_mem_regwrite),
    .o_mem_read (w_mem_mem_read)
  );

  five_stage_writer_tracker_stage #(.RdBits(REG_INDEX_BITS)) u_wb_stage (
    .clock      (clock),
    .reset      (reset),
    .i_hold     (bus.memory_stall),
    .i_bubble   (1'b0),
    .i_valid    (w_mem_valid),
    .i_rd       (w_mem_rd),
    .i_regwrite (w_mem_regwrite),
    .i_mem_read (w_mem_mem_read),
    .o_valid    (w_wb_valid),
    .o_rd       (w_wb_rd),
    .o_regwrite (w_wb_regwrite),
    .o_mem_read (w_wb_mem_read_unused)
  );

  // x0 is never a real producer, so it is excluded even when regwrite is set.
  function automatic logic src_hit(input logic                      used,
                                   input logic                      s_valid,
                                   input logic                      s_regwrite,
                                   input logic [REG_INDEX_BITS-1:0] s_rd,
                                   input logic [REG_INDEX_BITS-1:0] rs);
    return used & s_valid & s_regwrite & (s_rd != REG_INDEX_BITS'(REG_ZERO)) & (s_rd == rs);
  endfunction

  always_comb begin
    w_rs1_ex  = bus.decode_valid &
                src_hit(bus.decode_rs1_used, w_ex_valid, w_ex_regwrite, w_ex_rd, bus.decode_rs1);
    w_rs1_mem = bus.decode_valid &
                src_hit(bus.decode_rs1_used, w_mem_valid, w_mem_regwrite, w_mem_rd, bus.decode_rs1);
    w_rs1_wb  = bus.decode_valid &
                src_hit(bus.decode_rs1_used, w_wb_valid, w_wb_regwrite, w_wb_rd, bus.decode_rs1);
    w_rs2_ex  = bus.decode_valid &
                src_hit(bus.decode_rs2_used, w_ex_valid, w_ex_regwrite, w_ex_rd, bus.decode_rs2);
    w_rs2_mem = bus.decode_valid &
                src_hit(bus.decode_rs2_used, w_mem_valid, w_mem_regwrite, w_mem_rd, bus.decode_rs2);
    w_rs2_wb  = bus.decode_valid &
                src_hit(bus.decode_rs2_used, w_wb_valid, w_wb_regwrite, w_wb_rd, bus.decode_rs2);
  end

  // Only a load still in EX must stall; MEM and WB loads are forwarded.
  assign w_true_data_hazard = w_ex_valid & w_ex_mem_read & (w_rs1_ex | w_rs2_ex);

  assign bus.rs1_hazard_execute   = w_rs1_ex;
  assign bus.rs1_hazard_memory    = w_rs1_mem;
  assign bus.rs1_hazard_writeback = w_rs1_wb;
  assign bus.rs2_hazard_execute   = w_rs2_ex;
  assign bus.rs2_hazard_memory    = w_rs2_mem;
  assign bus.rs2_hazard_writeback = w_rs2_wb;
  assign bus.true_data_hazard     = w_true_data_hazard;

`ifdef HAZARD_STALL_COUNTER_EN
  logic [STALL_COUNT_BITS-1:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_true_data_hazard && !bus.memory_stall && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + STALL_COUNT_BITS'(1);
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + CYCLE_COUNT_BITS'(1);
    end
  end

  assign bus.scan_active = bus.scan &
                           (longint'(r_cycle) >= longint'(SCAN_CYCLES_MIN)) &
                           (longint'(r_cycle) <= longint'(SCAN_CYCLES_MAX));
  assign bus.scan_cycle  = r_cycle;
  assign bus.scan_core   = 32'(CORE);

endmodule

// File: tb/tb_five_stage_hazard_detection_unit.sv
// Directed bench for five_stage_hazard_detection_unit; honours HAZARD_STALL_COUNTER_EN if defined.
module tb_five_stage_hazard_detection_unit;

`ifdef HAZARD_STALL_COUNTER_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  int tests_run    = 0;
  int tests_failed = 0;

  five_stage_hazard_detection_unit_if #(.REG_INDEX_BITS(5)) bus ();

  five_stage_hazard_detection_unit #(
    .CORE            (0),
    .REG_INDEX_BITS  (5),
    .SCAN_CYCLES_MIN (0),
    .SCAN_CYCLES_MAX (1000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.scan_active) begin
      $display("[SCAN] core=%0d cycle=%0d ex=%b/%0d/%b/%b mem=%b/%0d/%b wb=%b/%0d/%b flags=%b%b%b_%b%b%b tdh=%b",
               bus.scan_core, bus.scan_cycle,
               dut.w_ex_valid, dut.w_ex_rd, dut.w_ex_regwrite, dut.w_ex_mem_read,
               dut.w_mem_valid, dut.w_mem_rd, dut.w_mem_regwrite,
               dut.w_wb_valid, dut.w_wb_rd, dut.w_wb_regwrite,
               bus.rs1_hazard_execute, bus.rs1_hazard_memory, bus.rs1_hazard_writeback,
               bus.rs2_hazard_execute, bus.rs2_hazard_memory, bus.rs2_hazard_writeback,
               bus.true_data_hazard);
    end
  end

  // {rs1_ex, rs1_mem, rs1_wb, rs2_ex, rs2_mem, rs2_wb, true_data_hazard}
  function automatic logic [6:0] flags();
    return {bus.rs1_hazard_execute, bus.rs1_hazard_memory, bus.rs1_hazard_writeback,
            bus.rs2_hazard_execute, bus.rs2_hazard_memory, bus.rs2_hazard_writeback,
            bus.true_data_hazard};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.decode_valid    = 1'b0;
    bus.decode_rs1      = 5'd0;
    bus.decode_rs2      = 5'd0;
    bus.decode_rs1_used = 1'b0;
    bus.decode_rs2_used = 1'b0;
    bus.decode_rd       = 5'd0;
    bus.decode_regwrite = 1'b0;
    bus.decode_mem_read = 1'b0;
    bus.flush_execute   = 1'b0;
    bus.memory_stall    = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic regwrite, input logic mem_read);
    idle();
    bus.decode_valid    = 1'b1;
    bus.decode_rd       = rd;
    bus.decode_regwrite = regwrite;
    bus.decode_mem_read = mem_read;
  endtask

  task automatic consume(input logic [4:0] rs1, input logic used1,
                         input logic [4:0] rs2, input logic used2);
    idle();
    bus.decode_valid    = 1'b1;
    bus.decode_rs1      = rs1;
    bus.decode_rs1_used = used1;
    bus.decode_rs2      = rs2;
    bus.decode_rs2_used = used2;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.scan = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (flags() !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected %b", flags(), 7'b0000000);
    end
    tests_run++;
    if (bus.stall_cycles !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_stall_cycles: got %0d expected 0", bus.stall_cycles);
    end
    tests_run++;
    if (bus.scan_cycle !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cycle_counter: got %0d expected 0", bus.scan_cycle);
    end
    consume(5'd5, 1'b1, 5'd6, 1'b1);
    #1;
    tests_run++;
    if (flags() !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL empty_pipe_flags: got %b expected %b", flags(), 7'b0000000);
    end
  endtask

  task automatic test_alu_forward();
    bus.scan = 1'b1;
    issue(5'd5, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (bus.scan_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL scan_active: got %b expected 1", bus.scan_active);
    end
    tick();
    consume(5'd5, 1'b1, 5'd5, 1'b1);
    #1;
    tests_run++;
    if (flags() !== 7'b1001000) begin
      tests_failed++;
      $display("FAIL alu_ex_flags: got %b expected %b", flags(), 7'b1001000);
    end
    tick();
    tests_run++;
    if (flags() !== 7'b0100100) begin
      tests_failed++;
      $display("FAIL alu_mem_flags: got %b expected %b", flags(), 7'b0100100);
    end
    tick();
    tests_run++;
    if (flags() !== 7'b0010010) begin
      tests_failed++;
      $display("FAIL alu_wb_flags: got %b expected %b", flags(), 7'b0010010);
    end
    tick();
    tests_run++;
    if (flags() !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL alu_retired_flags: got %b expected %b", flags(), 7'b0000000);
    end
    bus.scan = 1'b0;
    drain();
  endtask

  task automatic test_load_use();
    issue(5'd7, 1'b1, 1'b1);
    tick();
    consume(5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    tests_run++;
    if (flags() !== 7'b0001001) begin
      tests_failed++;
      $display("FAIL load_use_stall: got %b expected %b", flags(), 7'b0001001);
    end
    tick();
    tests_run++;
    if (flags() !== 7'b0000100) begin
      tests_failed++;
      $display("FAIL load_use_released: got %b expected %b", flags(), 7'b0000100);
    end
    tests_run++;
    if (bus.stall_cycles !== (StallEn ? 32'd1 : 32'd0)) begin
      tests_failed++;
      $display("FAIL load_use_stall_cycles: got %0d expected %0d",
               bus.stall_cycles, StallEn ? 1 : 0);
    end
    drain();
  endtask

  task automatic test_memory_stall();
    issue(5'd7, 1'b1, 1'b1);
    tick();
    consume(5'd7, 1'b1, 5'd0, 1'b0);
    bus.memory_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (flags() !== 7'b1000001 || bus.stall_cycles !== (StallEn ? 32'd1 : 32'd0)) begin
        tests_failed++;
        $display("FAIL mem_stall_hold[%0d]: got flags=%b stall=%0d expected flags=%b stall=%0d",
                 i, flags(), bus.stall_cycles, 7'b1000001, StallEn ? 1 : 0);
      end
      tick();
    end
    bus.memory_stall = 1'b0;
    #1;
    tests_run++;
    if (flags() !== 7'b1000001) begin
      tests_failed++;
      $display("FAIL mem_stall_dropped: got %b expected %b", flags(), 7'b1000001);
    end
    tick();
    tests_run++;
    if (flags() !== 7'b0100000 || bus.stall_cycles !== (StallEn ? 32'd2 : 32'd0)) begin
      tests_failed++;
      $display("FAIL mem_stall_release: got flags=%b stall=%0d expected flags=%b stall=%0d",
               flags(), bus.stall_cycles, 7'b0100000, StallEn ? 2 : 0);
    end
    drain();
  endtask

  task automatic test_x0_and_flush();
    issue(5'd0, 1'b1, 1'b0);
    tick();
    consume(5'd0, 1'b1, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (flags() !== 7'b0000000) begin
        tests_failed++;
        $display("FAIL x0_no_hazard[%0d]: got %b expected %b", i, flags(), 7'b0000000);
      end
      tick();
    end
    drain();
    issue(5'd9, 1'b1, 1'b0);
    bus.flush_execute = 1'b1;
    tick();
    consume(5'd9, 1'b1, 5'd9, 1'b1);
    #1;
    tests_run++;
    if (flags() !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL flushed_producer: got %b expected %b", flags(), 7'b0000000);
    end
    drain();
    // Flush coinciding with a load-use stall still inserts a single bubble.
    issue(5'd7, 1'b1, 1'b1);
    tick();
    consume(5'd7, 1'b1, 5'd0, 1'b0);
    bus.flush_execute = 1'b1;
    #1;
    tests_run++;
    if (flags() !== 7'b1000001) begin
      tests_failed++;
      $display("FAIL flush_with_stall: got %b expected %b", flags(), 7'b1000001);
    end
    tick();
    consume(5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    tests_run++;
    if (flags() !== 7'b0100000 || bus.stall_cycles !== (StallEn ? 32'd3 : 32'd0)) begin
      tests_failed++;
      $display("FAIL flush_single_count: got flags=%b stall=%0d expected flags=%b stall=%0d",
               flags(), bus.stall_cycles, 7'b0100000, StallEn ? 3 : 0);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    issue(5'd7, 1'b1, 1'b1);
    tick();
    consume(5'd7, 1'b1, 5'd7, 1'b1);
    #1;
    tests_run++;
    if (flags() !== 7'b1001001) begin
      tests_failed++;
      $display("FAIL pre_reset_stall: got %b expected %b", flags(), 7'b1001001);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (flags() !== 7'b0000000 || bus.stall_cycles !== 32'd0) begin
      tests_failed++;
      $display("FAIL midstream_reset: got flags=%b stall=%0d expected flags=%b stall=0",
               flags(), bus.stall_cycles, 7'b0000000);
    end
    tests_run++;
    if (bus.scan_cycle !== 32'd0) begin
      tests_failed++;
      $display("FAIL midstream_reset_cycle: got %0d expected 0", bus.scan_cycle);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_memory_stall();
    test_x0_and_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/five_stage_hazard_detection_unit.md
Name: five_stage_hazard_detection_unit

Overview:
- Upstream neighbour of five_stage_bypass_unit in the five-stage core.
- Shadows destination-register info of in-flight instructions through execute, memory and writeback stages in a small internal pipeline.
- Compares decode-stage source registers against those stages and produces the per-stage hazard flags and true_data_hazard (load-use stall) that the bypass unit and decode stall logic consume.

Parameters:
- CORE, 0, core ID printed in scan output
- REG_INDEX_BITS, 5, register index width
- SCAN_CYCLES_MIN, 0, first cycle for which scan output prints
- SCAN_CYCLES_MAX, 1000, last cycle for which scan output prints

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- decode_valid  input  1  decode holds a real instruction
- decode_rs1  input  REG_INDEX_BITS  source 1 index
- decode_rs2  input  REG_INDEX_BITS  source 2 index
- decode_rs1_used  input  1  instruction reads rs1
- decode_rs2_used  input  1  instruction reads rs2
- decode_rd  input  REG_INDEX_BITS  destination index
- decode_regwrite  input  1  instruction writes rd
- decode_mem_read  input  1  instruction is a load
- flush_execute  input  1  squash the instruction leaving decode (branch/jump redirect)
- memory_stall  input  1  memory back-pressure; freezes the tracker
- rs1_hazard_execute, rs1_hazard_memory, rs1_hazard_writeback  output  1 each  rs1 matches that stage's rd
- rs2_hazard_execute, rs2_hazard_memory, rs2_hazard_writeback  output  1 each  rs2 matches that stage's rd
- true_data_hazard  output  1  load-use stall request
- stall_cycles  output  32  load-use stall count (see Optional Feature)
- scan  input  1  enable debug print

Behaviour:
- Each tracker stage (EX, MEM, WB) holds: valid, rd, regwrite, mem_read.
- Reset (synchronous): all stage valid=0; cycle counter=0; stall_cycles=0. All hazard outputs and true_data_hazard are therefore 0 in the cycle after reset.
- Per clock, when reset=0:
  - memory_stall=1: all three stages hold.
  - Otherwise, WB<=MEM and MEM<=EX.
  - EX<=bubble (valid=0) if true_data_hazard | flush_execute | !decode_valid; otherwise EX<={1, decode_rd, decode_regwrite, decode_mem_read}.
- Hazard flags (combinational, per stage S, per source n):
  - rsN_hazard_S = decode_valid & rsN_used & S.valid & S.regwrite & (S.rd != 0) & (S.rd == decode_rsN).
  - Multiple stages may assert together; priority selection belongs to the bypass unit.
- true_data_hazard (combinational) = EX.valid & EX.mem_read & (rs1_hazard_execute | rs2_hazard_execute).
  - A load in MEM or WB never stalls; it is forwarded.
- One load-use hazard produces exactly one bubble: the next cycle the load moves to MEM and the stall drops, provided memory_stall=0.
- If memory_stall=1 while true_data_hazard=1, the stall persists until the tracker advances.
- flush_execute together with true_data_hazard: one bubble is inserted, with no double counting.
- x0 as rd never creates a hazard, even when regwrite=1.
- Cycle counter increments every cycle. When scan=1 and the counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], print CORE, the counter value, the stage entries and the hazard outputs.

Optional Feature:
- Macro HAZARD_STALL_COUNTER_EN.
- Defined: stall_cycles increments on each clock where true_data_hazard=1 and memory_stall=0; it saturates at 32'hFFFF_FFFF and is cleared by reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized; the port remains present.

Decomposition:
- Shared package/header five_stage_pkg:
  - REG_INDEX_BITS default
  - REG_ZERO constant (5'd0)
  - tracker-entry field widths and bubble constant
- One natural sub-module, five_stage_writer_tracker_stage: a single stage register with hold and bubble-insert controls, instantiated three times.
- The comparator logic stays in the top module.

Test Plan:
1. Reset, then decode_valid=1, rs1=5, rs2=6, empty pipeline -> all hazard outputs 0, true_data_hazard=0.
2. Issue ALU op rd=5 regwrite=1, then consumer rs1=5, rs2=5 -> next cycle rs1_hazard_execute=1, rs2_hazard_execute=1, true_data_hazard=0. One and two cycles later, the MEM then WB flags assert in turn.
3. Issue load rd=7, then consumer rs2=7 -> true_data_hazard=1 for exactly 1 cycle. The following cycle rs2_hazard_memory=1 and true_data_hazard=0. With the macro defined, stall_cycles=1.
4. Load rd=7 followed by consumer rs1=7 while memory_stall=1 for 3 cycles -> true_data_hazard stays 1 for all 3 cycles and stall_cycles does not increment; it clears 1 cycle after memory_stall drops.
5. ALU op rd=0 regwrite=1, then consumer rs1=0 -> all hazards 0. Separately, rd=9 issued with flush_execute=1, then consumer rs1=9 -> rs1_hazard_execute=0.
6. Assert reset mid-stream with a load in EX and a matching consumer in decode -> the cycle after reset, true_data_hazard=0, all flags 0 and stall_cycles=0.
